// File: rtl/spi_rx_async_fifo_rd_pkg.sv
// Shared constants and types for the SPI inbound FIFO read path.
// Interface codes, transfer sizes and the read-side state encoding.
package spi_rx_async_fifo_rd_pkg;

  localparam logic [3:0] IFCODE_ACT    = 4'd1;
  localparam logic [3:0] IFCODE_WEI    = 4'd2;
  localparam logic [3:0] IFCODE_FLGACT = 4'd3;
  localparam logic [3:0] IFCODE_FLGWEI = 4'd4;

  localparam int unsigned RD_SIZE_ACT    = 16;
  localparam int unsigned RD_SIZE_WEI    = 64;
  localparam int unsigned RD_SIZE_FLGACT = 4;
  localparam int unsigned RD_SIZE_FLGWEI = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_WAIT,
    ST_RD_DATA,
    ST_DRAIN,
    ST_RESET_FIFO
  } rx_state_e;

  // Unknown codes fall back to an activation-sized transfer.
  function automatic int unsigned rd_size_of(input logic [3:0] code);
    unique case (1'b1)
      code == IFCODE_ACT:    return RD_SIZE_ACT;
      code == IFCODE_WEI:    return RD_SIZE_WEI;
      code == IFCODE_FLGACT: return RD_SIZE_FLGACT;
      code == IFCODE_FLGWEI: return RD_SIZE_FLGWEI;
      default:               return RD_SIZE_ACT;
    endcase
  endfunction

endpackage

// File: rtl/spi_rx_async_fifo_rd_fifo.sv
// Gray-pointer dual-clock FIFO with registered read data.
// The occupancy port exists only with SPI_RX_ERR_FLAG_EN.
module fifo_async_rd #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          rst_n,
  input  logic          wr_clk,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_clk,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  input  logic          clr
`ifdef SPI_RX_ERR_FLAG_EN
  ,
  output logic [AW:0]   level
`endif
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wbin, wgray, wbin_nxt;
  logic [AW:0] rbin, rgray, rbin_nxt;
  logic [AW:0] wgray_s1, wgray_s2;
  logic [AW:0] rgray_s1, rgray_s2;

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign wbin_nxt = wbin + (AW+1)'(1);
  assign rbin_nxt = rbin + (AW+1)'(1);

  assign full  = wgray == {~rgray_s2[AW:AW-1], rgray_s2[AW-2:0]};
  assign empty = rgray == wgray_s2;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin     <= '0;
      wgray    <= '0;
      rgray_s1 <= '0;
      rgray_s2 <= '0;
    end else begin
      rgray_s1 <= rgray;
      rgray_s2 <= rgray_s1;
      if (wr_en && !full) begin
        wbin  <= wbin_nxt;
        wgray <= (wbin_nxt >> 1) ^ wbin_nxt;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_en && !full) mem[wbin[AW-1:0]] <= din;
  end

  // clr flushes: the read pointer catches up with the write pointer.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin     <= '0;
      rgray    <= '0;
      wgray_s1 <= '0;
      wgray_s2 <= '0;
      dout     <= '0;
    end else begin
      wgray_s1 <= wgray;
      wgray_s2 <= wgray_s1;
      if (clr) begin
        rbin  <= g2b(wgray_s2);
        rgray <= wgray_s2;
      end else if (rd_en && !empty) begin
        rbin  <= rbin_nxt;
        rgray <= (rbin_nxt >> 1) ^ rbin_nxt;
        dout  <= mem[rbin[AW-1:0]];
      end
    end
  end

`ifdef SPI_RX_ERR_FLAG_EN
  assign level = g2b(wgray_s2) - rbin;
`endif

endmodule

// File: rtl/spi_rx_async_fifo_rd.sv
// SPI inbound path: pad words into a dual-clock FIFO, drained by the core.
// Define SPI_RX_ERR_FLAG_EN to build the sticky rd_err overrun/short flag.
module spi_rx_async_fifo_rd
  import spi_rx_async_fifo_rd_pkg::*;
#(
  parameter int SPI_WIDTH       = 32,
  parameter int ADDR_WIDTH_FIFO = 3,
  parameter int RX_WIDTH        = 20
) (
  input  logic                 clk_chip,
  input  logic                 reset_n_chip,
  input  logic                 O_spi_sck,
  input  logic                 O_spi_cs_n,
  input  logic [SPI_WIDTH-1:0] IO_spi_data,
  output logic                 config_req,
  output logic                 spi_full,
  output logic                 config_ready,
  input  logic                 config_paulse,
  input  logic [3:0]           config_data,
  output logic                 rd_ready,
  input  logic                 rd_req,
  output logic                 rd_valid,
  output logic [SPI_WIDTH-1:0] rd_data,
  output logic                 rd_err
);

  rx_state_e state, state_nxt;

  logic                 cs_d;
  logic [2:0]           cs_sync, csd_sync;
  logic                 cs_s, csd_s;
  logic                 empty, full, pop, clr;
  logic [RX_WIDTH-1:0]  rd_size, rd_count;
  logic                 rd_done;
`ifdef SPI_RX_ERR_FLAG_EN
  logic [ADDR_WIDTH_FIFO:0] level;
`endif

  fifo_async_rd #(
    .DW (SPI_WIDTH),
    .AW (ADDR_WIDTH_FIFO)
  ) u_fifo (
    .rst_n  (reset_n_chip),
    .wr_clk (O_spi_sck),
    .wr_en  (!O_spi_cs_n),
    .din    (IO_spi_data),
    .rd_clk (clk_chip),
    .rd_en  (pop),
    .dout   (rd_data),
    .empty  (empty),
    .full   (full),
    .clr    (clr)
`ifdef SPI_RX_ERR_FLAG_EN
    ,
    .level  (level)
`endif
  );

  assign spi_full = full;

  // Delayed cs copy filters single-cycle deselects during a burst.
  always_ff @(posedge O_spi_sck or negedge reset_n_chip) begin
    if (!reset_n_chip) cs_d <= 1'b1;
    else               cs_d <= O_spi_cs_n;
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      cs_sync  <= '1;
      csd_sync <= '1;
    end else begin
      cs_sync  <= {cs_sync[1:0], O_spi_cs_n};
      csd_sync <= {csd_sync[1:0], cs_d};
    end
  end

  assign cs_s  = cs_sync[2];
  assign csd_s = csd_sync[2];

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:       if (config_paulse) state_nxt = ST_CONFIG;
      ST_CONFIG:     state_nxt = ST_WAIT;
      ST_WAIT:       if (!cs_s) state_nxt = ST_RD_DATA;
      ST_RD_DATA:    if (cs_s && csd_s) state_nxt = ST_DRAIN;
      ST_DRAIN:      if (rd_done) state_nxt = ST_RESET_FIFO;
      ST_RESET_FIFO: state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  assign config_ready = state == ST_IDLE;
  assign clr          = state == ST_RESET_FIFO;
  assign rd_ready     = (state == ST_WAIT || state == ST_RD_DATA ||
                         state == ST_DRAIN) && !empty && !rd_done;
  assign pop          = rd_req && rd_ready;

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      config_req <= 1'b0;
      rd_size    <= '0;
      rd_count   <= '0;
      rd_done    <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (state == ST_IDLE && config_paulse) begin
        config_req <= 1'b1;
        rd_size    <= RX_WIDTH'(rd_size_of(config_data));
      end else if (state == ST_WAIT && !cs_s) begin
        config_req <= 1'b0;
      end
      if (state == ST_IDLE) begin
        rd_count <= '0;
        rd_done  <= 1'b0;
      end else if (pop) begin
        rd_count <= rd_count + RX_WIDTH'(1);
        if (rd_count == rd_size - RX_WIDTH'(1)) rd_done <= 1'b1;
      end
    end
  end

`ifdef SPI_RX_ERR_FLAG_EN
  logic       ovf_tgl;
  logic [3:0] ovf_sync;
  logic       short_xfer;

  // Each dropped write flips the toggle; the core side edge-detects it.
  always_ff @(posedge O_spi_sck or negedge reset_n_chip) begin
    if (!reset_n_chip)          ovf_tgl <= 1'b0;
    else if (!O_spi_cs_n && full) ovf_tgl <= ~ovf_tgl;
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) ovf_sync <= '0;
    else               ovf_sync <= {ovf_sync[2:0], ovf_tgl};
  end

  assign short_xfer = state == ST_RD_DATA && state_nxt == ST_DRAIN &&
                      (rd_count + RX_WIDTH'(level)) < rd_size;

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) rd_err <= 1'b0;
    else if (config_paulse) rd_err <= 1'b0;
    else if ((ovf_sync[3] ^ ovf_sync[2]) || short_xfer) rd_err <= 1'b1;
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule
